alu_cmd_sequencer: RTL and testbench

Clocked command front-end that drives the combinational ALU. It accepts operation commands over a valid/ready handshake and registers the operands onto the ALU ports. It holds `alu_enable` for a per-opcode settle window, then captures the result and compare flags and returns them with the command tag over a second valid/ready handshake. Illegal opcodes and divide-by-zero are trapped here and never reach the ALU.

---
 rtl/alu_cmd_sequencer_if.sv | 30 +++
 rtl/alu_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response channels between a requester and alu_cmd_sequencer.
// The requester drives the master side, and the sequencer implements the slave side.
interface alu_cmd_sequencer_if #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned TAG_WIDTH = 4
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [3:0]             cmd_opcode;
  logic [IN_WIDTH-1:0]    cmd_a;
  logic [IN_WIDTH-1:0]    cmd_b;
  logic [TAG_WIDTH-1:0]   cmd_tag;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [2*IN_WIDTH-1:0]  rsp_result;
  logic [2:0]             rsp_flags;
  logic [TAG_WIDTH-1:0]   rsp_tag;
  logic                   rsp_error;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_error
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequences one command at a time onto a combinational ALU, waits a per-opcode
// settle window, and returns the captured result. Illegal opcodes and divide-by-zero are trapped locally.
module alu_cmd_sequencer #(
  parameter int unsigned IN_WIDTH      = 8,
  parameter int unsigned TAG_WIDTH     = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned MULDIV_SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_cmd_sequencer_if.slave    bus,
  output logic [IN_WIDTH-1:0]   alu_a_o,
  output logic [IN_WIDTH-1:0]   alu_b_o,
  output logic [3:0]            alu_opcode_o,
  output logic                  alu_enable_o,
  input  logic [2*IN_WIDTH-1:0] alu_result_i,
  input  logic                  alu_greater_i,
  input  logic                  alu_equal_i,
  input  logic                  alu_less_i,
  output logic [15:0]           op_count_o
);

  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_DIV = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1001;

  localparam int unsigned MAX_SETTLE = (SETTLE_CYCLES > MULDIV_SETTLE) ? SETTLE_CYCLES : MULDIV_SETTLE;
  localparam int unsigned CNT_W      = (MAX_SETTLE > 1) ? $clog2(MAX_SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_SETTLE - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]    alu_a_q, alu_a_d;
  logic [IN_WIDTH-1:0]    alu_b_q, alu_b_d;
  logic [3:0]             alu_op_q, alu_op_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [2*IN_WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic [2:0]             rsp_flags_q, rsp_flags_d;
  logic [TAG_WIDTH-1:0]   rsp_tag_q, rsp_tag_d;
  logic                   rsp_error_q, rsp_error_d;
  logic [15:0]            op_count_q, op_count_d;

  logic cmd_err;
  logic cmd_muldiv;

  assign cmd_err    = (bus.cmd_opcode >= 4'b1010) ||
                      ((bus.cmd_opcode == OP_DIV) && (bus.cmd_b == '0));
  assign cmd_muldiv = (bus.cmd_opcode == OP_MUL) || (bus.cmd_opcode == OP_DIV);

  // The response fields are loaded only on entry to RESP, so they stay stable
  // through EXEC and backpressure. The tag is staged in tag_q until then.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    tag_d        = tag_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_error_d  = rsp_error_q;
    op_count_d   = op_count_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          tag_d = bus.cmd_tag;
          if (cmd_err) begin
            rsp_result_d = '0;
            rsp_flags_d  = '0;
            rsp_error_d  = 1'b1;
            rsp_tag_d    = bus.cmd_tag;
            state_d      = RESP;
          end else begin
            alu_a_d  = bus.cmd_a;
            alu_b_d  = bus.cmd_b;
            alu_op_d = bus.cmd_opcode;
            cnt_d    = cmd_muldiv ? MULDIV_LOAD : SETTLE_LOAD;
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_result_d = alu_result_i;
          rsp_flags_d  = (alu_op_q == OP_CMP) ? {alu_greater_i, alu_equal_i, alu_less_i} : 3'b000;
          rsp_error_d  = 1'b0;
          rsp_tag_d    = tag_q;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_tag_q    <= '0;
      rsp_error_q  <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      tag_q        <= tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_error_q  <= rsp_error_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_error  = rsp_error_q;

  assign alu_enable_o = (state_q == EXEC);
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_opcode_o = alu_op_q;
  assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer. The bench includes a behavioural ALU stub and a transaction-level model.
// Directed commands are checked against literal values, and each cycle's outputs are checked against the model.
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.IN_WIDTH(8), .TAG_WIDTH(4)) ifc ();

  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_en;
  logic [15:0] alu_res;
  logic        alu_g, alu_e, alu_l;
  logic [15:0] op_count;

  alu_cmd_sequencer #(
    .IN_WIDTH(8), .TAG_WIDTH(4), .SETTLE_CYCLES(1), .MULDIV_SETTLE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_opcode_o(alu_op), .alu_enable_o(alu_en),
    .alu_result_i(alu_res), .alu_greater_i(alu_g), .alu_equal_i(alu_e), .alu_less_i(alu_l),
    .op_count_o(op_count)
  );

  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0: return 16'(a) + 16'(b);
      4'd1: return 16'(a) - 16'(b);
      4'd2: return {8'h00, a & b};
      4'd3: return {8'h00, a | b};
      4'd4: return {8'h00, a ^ b};
      4'd5: return 16'(a) << 1;
      4'd6: return {8'h00, a >> 1};
      4'd7: return 16'(a) * 16'(b);
      4'd8: return (b == 8'h00) ? 16'h0000 : {8'h00, a / b};
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_res = alu_ref(alu_op, alu_a, alu_b);
  assign alu_g   = alu_a > alu_b;
  assign alu_e   = alu_a == alu_b;
  assign alu_l   = alu_a < alu_b;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: remaining enable cycles, a pending response, and visible response fields.
  int          m_exec_left;
  bit          m_resp;
  logic [15:0] m_count;
  logic [7:0]  m_a, m_b;
  logic [3:0]  m_op;
  logic [15:0] p_res, m_res;
  logic [2:0]  p_fl, m_fl;
  logic [3:0]  p_tag, m_tag;
  logic        m_err;
  bit          wrap_req = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_exec_left = 0; m_resp = 1'b0; m_count = 16'h0;
      m_a = 8'h0; m_b = 8'h0; m_op = 4'h0;
      p_res = 16'h0; p_fl = 3'b0; p_tag = 4'h0;
      m_res = 16'h0; m_fl = 3'b0; m_tag = 4'h0; m_err = 1'b0;
    end else begin
      if (m_resp) begin
        if (ifc.rsp_ready) begin
          m_resp  = 1'b0;
          m_count = m_count + 16'd1;
        end
      end else if (m_exec_left > 0) begin
        m_exec_left--;
        if (m_exec_left == 0) begin
          m_resp = 1'b1; m_res = p_res; m_fl = p_fl; m_tag = p_tag; m_err = 1'b0;
        end
      end else if (ifc.cmd_valid) begin
        if (ifc.cmd_opcode > 4'd9 || (ifc.cmd_opcode == 4'd8 && ifc.cmd_b == 8'h00)) begin
          m_resp = 1'b1; m_res = 16'h0; m_fl = 3'b0; m_tag = ifc.cmd_tag; m_err = 1'b1;
        end else begin
          m_a = ifc.cmd_a; m_b = ifc.cmd_b; m_op = ifc.cmd_opcode;
          m_exec_left = (ifc.cmd_opcode == 4'd7 || ifc.cmd_opcode == 4'd8) ? 2 : 1;
          p_res = alu_ref(ifc.cmd_opcode, ifc.cmd_a, ifc.cmd_b);
          p_fl  = (ifc.cmd_opcode == 4'd9) ?
                  {ifc.cmd_a > ifc.cmd_b, ifc.cmd_a == ifc.cmd_b, ifc.cmd_a < ifc.cmd_b} : 3'b000;
          p_tag = ifc.cmd_tag;
        end
      end
      if (wrap_req) m_count = 16'hFFFF;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmd_ready",  32'(ifc.cmd_ready),  32'(!m_resp && m_exec_left == 0));
      chk("alu_enable", 32'(alu_en),         32'(m_exec_left > 0));
      chk("rsp_valid",  32'(ifc.rsp_valid),  32'(m_resp));
      chk("op_count",   32'(op_count),       32'(m_count));
      chk("alu_a",      32'(alu_a),          32'(m_a));
      chk("alu_b",      32'(alu_b),          32'(m_b));
      chk("alu_opcode", 32'(alu_op),         32'(m_op));
      chk("rsp_result", 32'(ifc.rsp_result), 32'(m_res));
      chk("rsp_flags",  32'(ifc.rsp_flags),  32'(m_fl));
      chk("rsp_tag",    32'(ifc.rsp_tag),    32'(m_tag));
      chk("rsp_error",  32'(ifc.rsp_error),  32'(m_err));
    end
  end

  // Issues one command and returns the response fields, the number of cycles until rsp_valid, and the count of enable cycles.
  task automatic do_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag, input int hold,
                        output int lat, output int en,
                        output logic [15:0] res, output logic [2:0] fl,
                        output logic err, output logic [3:0] tg);
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_opcode = op; ifc.cmd_a = a; ifc.cmd_b = b; ifc.cmd_tag = tag;
    ifc.rsp_ready = 1'b0;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    lat = 1; en = 0;
    while (!ifc.rsp_valid && lat < 20) begin
      if (alu_en) en++;
      @(negedge clk);
      lat++;
    end
    if (!ifc.rsp_valid) chk("rsp_valid_timeout", 32'(ifc.rsp_valid), 32'd1);
    res = ifc.rsp_result; fl = ifc.rsp_flags; err = ifc.rsp_error; tg = ifc.rsp_tag;
    for (int i = 0; i < hold; i++) begin
      ifc.cmd_valid = 1'b1; ifc.cmd_opcode = 4'd0; ifc.cmd_tag = 4'hF;
      @(negedge clk);
      chk("bp_rsp_valid",  32'(ifc.rsp_valid),  32'd1);
      chk("bp_cmd_ready",  32'(ifc.cmd_ready),  32'd0);
      chk("bp_rsp_result", 32'(ifc.rsp_result), 32'(res));
      chk("bp_rsp_tag",    32'(ifc.rsp_tag),    32'(tg));
    end
    ifc.cmd_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
  endtask

  int lat, en;
  logic [15:0] res;
  logic [2:0]  fl;
  logic        err;
  logic [3:0]  tg;

  initial begin
    ifc.cmd_valid = 1'b0; ifc.cmd_opcode = 4'h0; ifc.cmd_a = 8'h0; ifc.cmd_b = 8'h0;
    ifc.cmd_tag = 4'h0; ifc.rsp_ready = 1'b0;
    #2;
    chk("reset_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    chk("reset_alu_en",    32'(alu_en),        32'd0);
    chk("reset_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("reset_op_count",  32'(op_count),      32'd0);
    chk("reset_alu_a",     32'(alu_a),         32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    do_cmd(4'd0, 8'h12, 8'h34, 4'd3, 0, lat, en, res, fl, err, tg);
    chk("add_result", 32'(res), 32'h0046);
    chk("add_flags",  32'(fl),  32'd0);
    chk("add_error",  32'(err), 32'd0);
    chk("add_tag",    32'(tg),  32'd3);
    chk("add_enable_cycles", 32'(en), 32'd1);
    chk("add_latency", 32'(lat), 32'd2);

    do_cmd(4'd7, 8'hFF, 8'hFF, 4'd5, 0, lat, en, res, fl, err, tg);
    chk("mul_result", 32'(res), 32'hFE01);
    chk("mul_enable_cycles", 32'(en), 32'd2);

    do_cmd(4'd9, 8'd5, 8'd9, 4'd6, 0, lat, en, res, fl, err, tg);
    chk("cmp_flags", 32'(fl), 32'b001);

    do_cmd(4'd1, 8'd3, 8'd5, 4'd1, 0, lat, en, res, fl, err, tg);
    chk("sub_result", 32'(res), 32'hFFFE);
    chk("sub_flags",  32'(fl),  32'd0);

    do_cmd(4'd8, 8'd7, 8'd0, 4'd7, 0, lat, en, res, fl, err, tg);
    chk("div0_error",  32'(err), 32'd1);
    chk("div0_result", 32'(res), 32'd0);
    chk("div0_enable_cycles", 32'(en), 32'd0);
    chk("div0_latency", 32'(lat), 32'd1);
    chk("div0_tag", 32'(tg), 32'd7);

    do_cmd(4'hC, 8'd1, 8'd2, 4'd8, 0, lat, en, res, fl, err, tg);
    chk("illegal_error", 32'(err), 32'd1);
    chk("illegal_enable_cycles", 32'(en), 32'd0);

    do_cmd(4'd8, 8'd200, 8'd7, 4'd9, 5, lat, en, res, fl, err, tg);
    chk("div_result", 32'(res), 32'h001C);
    chk("div_enable_cycles", 32'(en), 32'd2);
    chk("bp_op_count", 32'(op_count), 32'd7);
    chk("bp_cmd_ready_after", 32'(ifc.cmd_ready), 32'd1);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_opcode = 4'd8; ifc.cmd_a = 8'd200; ifc.cmd_b = 8'd7; ifc.cmd_tag = 4'd2;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    chk("div_enable_before_reset", 32'(alu_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_alu_en",    32'(alu_en),        32'd0);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("rst_op_count",  32'(op_count),      32'd0);
    chk("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    do_cmd(4'd0, 8'h20, 8'h22, 4'hA, 0, lat, en, res, fl, err, tg);
    chk("post_rst_result", 32'(res), 32'h0042);
    chk("post_rst_tag",    32'(tg),  32'hA);
    chk("post_rst_count",  32'(op_count), 32'd1);

    // op_count wrap
    @(negedge clk);
    #1;
    force dut.op_count_q = 16'hFFFF;
    wrap_req = 1'b1;
    @(negedge clk);
    #1;
    release dut.op_count_q;
    wrap_req = 1'b0;
    chk("forced_count", 32'(op_count), 32'hFFFF);
    do_cmd(4'd9, 8'd4, 8'd4, 4'd1, 0, lat, en, res, fl, err, tg);
    chk("eq_flags", 32'(fl), 32'b010);
    chk("wrap_count", 32'(op_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
